// File: rtl/i2c_slave_regctrl_pkg.sv
// Shared definitions for the I2C slave register-map controller.
package i2c_regctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  localparam state_t     RST_STATE = ST_IDLE;
  localparam logic [7:0] RST_BYTE  = 8'h00;
  localparam logic       RST_BIT   = 1'b0;

endpackage

// File: rtl/i2c_slave_regctrl_edge_sync.sv
// Registers one slave handshake level and flags its rising/falling edges
// against the previous registered sample.
module edge_sync
  import i2c_regctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_level;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= RST_BIT;
      r_prev  <= RST_BIT;
    end else begin
      r_level <= din;
      r_prev  <= r_level;
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_prev;
  assign fall  = ~r_level & r_prev;

endmodule

// File: rtl/i2c_slave_regctrl.sv
// Register-map controller for the I2C slave: pointer handling, auto-increment,
// and a register file shared with a local host port.
module i2c_slave_regctrl
  import i2c_regctrl_pkg::*;
#(
  parameter  int unsigned NREG = 8,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          busy,
  input  logic          data_available,
  input  logic          data_request,
  input  logic [7:0]    data_o,
  output logic [7:0]    data_i,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic [7:0]    loc_rdata,
  output logic [AW-1:0] ptr,
  output logic          i2c_wr,
  output logic          loc_collision
);

  logic w_busy_lvl, w_busy_rise, w_busy_fall;
  logic w_da_lvl,   w_da_rise,   w_da_fall;
  logic w_dr_lvl,   w_dr_rise,   w_dr_fall;

  edge_sync u_busy (
    .clk   (clk),
    .rst   (rst),
    .din   (busy),
    .level (w_busy_lvl),
    .rise  (w_busy_rise),
    .fall  (w_busy_fall)
  );

  edge_sync u_da (
    .clk   (clk),
    .rst   (rst),
    .din   (data_available),
    .level (w_da_lvl),
    .rise  (w_da_rise),
    .fall  (w_da_fall)
  );

  edge_sync u_dr (
    .clk   (clk),
    .rst   (rst),
    .din   (data_request),
    .level (w_dr_lvl),
    .rise  (w_dr_rise),
    .fall  (w_dr_fall)
  );

  // Levels and the remaining edges are not needed by the pointer logic.
  logic w_unused;
  assign w_unused = ^{w_busy_lvl, w_da_lvl, w_da_fall, w_dr_lvl};

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr,   w_ptr_nxt;
  logic          w_i2c_we;
  logic          w_coll;
  logic [7:0]    r_regs [NREG];
  logic [7:0]    r_data_i;
  logic [7:0]    r_loc_rdata;
  logic          r_i2c_wr;
  logic          r_loc_coll;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // A data_available rise takes priority over any request edge in the same
  // cycle; a busy fall is applied after the data action.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_i2c_we    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_busy_rise) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        if (w_da_rise) begin
          w_ptr_nxt   = data_o[AW-1:0];
          w_state_nxt = ST_DATA;
        end else if (w_dr_rise) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_da_rise) begin
          w_i2c_we  = 1'b1;
          w_ptr_nxt = r_ptr + AW'(1);
        end else if (w_dr_fall) begin
          w_ptr_nxt = r_ptr + AW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_busy_fall) w_state_nxt = ST_IDLE;
  end

  assign w_coll = w_i2c_we & loc_we & (loc_addr == r_ptr);

  // The I2C port takes precedence on the same register; otherwise both land.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= RST_BYTE;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_i2c_we && (r_ptr == AW'(i)))
          r_regs[i] <= data_o;
        else if (loc_we && (loc_addr == AW'(i)))
          r_regs[i] <= loc_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_i    <= RST_BYTE;
      r_loc_rdata <= RST_BYTE;
      r_i2c_wr    <= RST_BIT;
      r_loc_coll  <= RST_BIT;
    end else begin
      r_data_i    <= r_regs[r_ptr];
      r_loc_rdata <= r_regs[loc_addr];
      r_i2c_wr    <= w_i2c_we;
      r_loc_coll  <= w_coll;
    end
  end

  assign data_i        = r_data_i;
  assign loc_rdata     = r_loc_rdata;
  assign ptr           = r_ptr;
  assign i2c_wr        = r_i2c_wr;
  assign loc_collision = r_loc_coll;

endmodule

// File: tb/tb_i2c_slave_regctrl.sv
// Scoreboard bench for i2c_slave_regctrl (NREG=8): stimulus queues expected
// results, a negedge monitor pops and compares them.
module tb_i2c_slave_regctrl;

  localparam int unsigned NREG = 8;
  localparam int unsigned AW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy = 1'b0;
  logic          data_available = 1'b0;
  logic          data_request = 1'b0;
  logic [7:0]    data_o = 8'h00;
  logic [7:0]    data_i;
  logic          loc_we = 1'b0;
  logic [AW-1:0] loc_addr = '0;
  logic [7:0]    loc_wdata = 8'h00;
  logic [7:0]    loc_rdata;
  logic [AW-1:0] ptr;
  logic          i2c_wr;
  logic          loc_collision;

  i2c_slave_regctrl #(.NREG(NREG)) dut (
    .clk            (clk),
    .rst            (rst),
    .busy           (busy),
    .data_available (data_available),
    .data_request   (data_request),
    .data_o         (data_o),
    .data_i         (data_i),
    .loc_we         (loc_we),
    .loc_addr       (loc_addr),
    .loc_wdata      (loc_wdata),
    .loc_rdata      (loc_rdata),
    .ptr            (ptr),
    .i2c_wr         (i2c_wr),
    .loc_collision  (loc_collision)
  );

  always #5 clk = ~clk;

  typedef enum int {S_PTR, S_DI, S_LRD, S_WR, S_COLL} sel_t;
  typedef struct { string name; sel_t sel; logic [7:0] exp; } smp_t;
  typedef struct { string name; logic [7:0] ptr; logic coll; } wr_t;

  smp_t q_smp[$];
  wr_t  q_wr[$];
  logic r_smp  = 1'b0;
  logic r_done = 1'b0;
  int   errs   = 0;
  int   checks = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample(input string name, input sel_t sel, input logic [7:0] exp);
    smp_t s;
    s.name = name; s.sel = sel; s.exp = exp;
    q_smp.push_back(s);
    r_smp = 1'b1;
    tick(1);
    r_smp = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    loc_addr = a;
    tick(2);
    sample(name, S_LRD, exp);
  endtask

  task automatic loc_wr(input logic [AW-1:0] a, input logic [7:0] d);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    tick(1);
    loc_we = 1'b0;
  endtask

  task automatic start_txn();
    busy = 1'b1;
    tick(4);
  endtask

  task automatic stop_txn();
    busy = 1'b0;
    tick(4);
  endtask

  task automatic waddr(input logic [7:0] b);
    data_o = b;
    tick(1);
    data_available = 1'b1;
    tick(4);
    data_available = 1'b0;
    tick(4);
  endtask

  // Optional local write is aligned with the cycle of the I2C register update.
  task automatic wdata(input string name, input logic [7:0] b, input logic [7:0] exp_ptr,
                       input logic exp_coll, input logic doloc,
                       input logic [AW-1:0] la, input logic [7:0] ld);
    wr_t w;
    w.name = name; w.ptr = exp_ptr; w.coll = exp_coll;
    q_wr.push_back(w);
    data_o = b;
    tick(1);
    data_available = 1'b1;
    tick(1);
    if (doloc) begin
      loc_addr = la; loc_wdata = ld; loc_we = 1'b1;
    end
    tick(1);
    loc_we = 1'b0;
    tick(3);
    data_available = 1'b0;
    tick(4);
  endtask

  task automatic rbyte(input string name, input logic [7:0] exp);
    data_request = 1'b1;
    tick(4);
    sample(name, S_DI, exp);
    data_request = 1'b0;
    tick(4);
  endtask

  always @(negedge clk) begin
    logic [7:0] act;
    if (r_smp) begin
      checks++;
      if (q_smp.size() == 0) begin
        errs++;
        $display("FAIL sample_queue_empty got=0 want=1");
      end else begin
        smp_t s;
        s = q_smp.pop_front();
        case (s.sel)
          S_PTR:   act = 8'(ptr);
          S_DI:    act = data_i;
          S_LRD:   act = loc_rdata;
          S_WR:    act = 8'(i2c_wr);
          default: act = 8'(loc_collision);
        endcase
        if (act !== s.exp) begin
          errs++;
          $display("FAIL %s got=%02h want=%02h", s.name, act, s.exp);
        end
      end
    end
    if (i2c_wr === 1'b1) begin
      checks++;
      if (q_wr.size() == 0) begin
        errs++;
        $display("FAIL unexpected_i2c_wr got=1 want=0 ptr=%0d", ptr);
      end else begin
        wr_t w;
        w = q_wr.pop_front();
        if (8'(ptr) !== w.ptr || loc_collision !== w.coll) begin
          errs++;
          $display("FAIL %s got ptr=%0d coll=%b want ptr=%0d coll=%b",
                   w.name, ptr, loc_collision, w.ptr, w.coll);
        end
      end
    end else if (loc_collision !== 1'b0) begin
      checks++;
      errs++;
      $display("FAIL stray_collision got=%b want=0", loc_collision);
    end
    if (r_done) begin
      checks++;
      if (q_wr.size() != 0 || q_smp.size() != 0) begin
        errs++;
        $display("FAIL pending_expected got=%0d want=0", q_wr.size() + q_smp.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    sample("rst_ptr",  S_PTR,  8'h00);
    sample("rst_di",   S_DI,   8'h00);
    sample("rst_lrd",  S_LRD,  8'h00);
    sample("rst_wr",   S_WR,   8'h00);
    sample("rst_coll", S_COLL, 8'h00);
    rst = 1'b0;
    tick(3);

    // Write txn; second byte collides with a local write to reg4.
    start_txn();
    waddr(8'h03);
    wdata("wr1_a5", 8'hA5, 8'd4, 1'b0, 1'b0, '0, 8'h00);
    wdata("wr1_5a_coll", 8'h5A, 8'd5, 1'b1, 1'b1, 3'd4, 8'h99);
    stop_txn();
    sample("wr1_ptr", S_PTR, 8'd5);
    chk_reg("wr1_reg3", 3'd3, 8'hA5);
    chk_reg("wr1_reg4", 3'd4, 8'h5A);

    // Same, local write to a different address: both land.
    start_txn();
    waddr(8'h03);
    wdata("wr2_a5", 8'hA5, 8'd4, 1'b0, 1'b0, '0, 8'h00);
    wdata("wr2_5a_nocoll", 8'h5A, 8'd5, 1'b0, 1'b1, 3'd2, 8'h99);
    stop_txn();
    chk_reg("wr2_reg2", 3'd2, 8'h99);
    chk_reg("wr2_reg4", 3'd4, 8'h5A);
    sample("wr2_ptr", S_PTR, 8'd5);

    // Current-address read from ptr=5.
    loc_wr(3'd5, 8'h77);
    loc_wr(3'd6, 8'h88);
    chk_reg("loc_reg5", 3'd5, 8'h77);
    start_txn();
    rbyte("rd_byte0", 8'h77);
    rbyte("rd_byte1", 8'h88);
    stop_txn();
    sample("rd_ptr", S_PTR, 8'd7);

    // Address wraps modulo NREG, pointer wraps 7 -> 0.
    start_txn();
    waddr(8'h0F);
    wdata("wrap_11", 8'h11, 8'd0, 1'b0, 1'b0, '0, 8'h00);
    wdata("wrap_22", 8'h22, 8'd1, 1'b0, 1'b0, '0, 8'h00);
    stop_txn();
    sample("wrap_ptr", S_PTR, 8'd1);
    chk_reg("wrap_reg7", 3'd7, 8'h11);
    chk_reg("wrap_reg0", 3'd0, 8'h22);

    // Reset in the middle of a transaction.
    start_txn();
    waddr(8'h02);
    loc_addr = 3'd7;
    busy = 1'b0;
    rst = 1'b1;
    tick(2);
    sample("mrst_ptr", S_PTR, 8'h00);
    sample("mrst_di",  S_DI,  8'h00);
    sample("mrst_lrd", S_LRD, 8'h00);
    sample("mrst_wr",  S_WR,  8'h00);
    rst = 1'b0;
    tick(4);
    start_txn();
    waddr(8'h01);
    wdata("post_rst_33", 8'h33, 8'd2, 1'b0, 1'b0, '0, 8'h00);
    stop_txn();
    chk_reg("post_rst_reg1", 3'd1, 8'h33);
    chk_reg("post_rst_reg7", 3'd7, 8'h00);
    sample("post_rst_ptr", S_PTR, 8'd2);

    tick(5);
    r_done = 1'b1;
  end

endmodule
